multi_tick_gen: RTL and testbench
=================================

// Module: multi_tick_gen
// PURPOSE
//  Multi-channel programmable tick generator; parametrised successor of the single fixed-rate divider.
//  Derives N_CH independent strobes from the system clock (50 MHz), each with its own run-time divisor.
//  Per channel: a 1-cycle tick and a 50%-duty square wave. Also supports global phase re-sync.
//  Feeds display scan, debounce sampling and blink logic, so the system needs no extra divider instances.
// PARAMETERS
//  N_CH     4           number of channels (1..16)
//  CNT_W    24          divisor/counter width in bits
//  DEF_DIV  12_500_000  divisor loaded into every channel at reset (4 Hz tick @ 50 MHz)
// PORTS
//  clk_i       in   1               system clock, 50 MHz
//  rst_i       in   1               asynchronous, active-high reset
//  en_i        in   N_CH            per-channel run enable
//  sync_i      in   1               1-cycle strobe: restart all channel counters in phase
//  div_wr_i    in   1               divisor write strobe
//  div_ch_i    in   4               channel index for the write
//  div_val_i   in   CNT_W           new divisor value
//  tick_o      out  N_CH            1-cycle tick per channel
//  sq_o        out  N_CH            square output per channel, frequency f_clk/(2*div)
// BEHAVIOUR
//  Reset: cnt=0, active_div=shadow_div=DEF_DIV, tick_o=0, sq_o=0, pend=0 for all channels.
//  All outputs are registered; no combinational path from any input to tick_o/sq_o.
//  Counting (en=1, active_div>=2):
//   - cnt runs 0..active_div-1, then wraps to 0.
//   - tick_o[ch] is high exactly the cycle after cnt==active_div-1, giving period = active_div cycles exactly.
//   - The first tick follows enable rise by active_div cycles.
//   - sq_o[ch] toggles on every tick.
//  active_div==1: tick_o[ch] is high every cycle while enabled; sq_o toggles every cycle.
//  active_div==0: channel is stopped. cnt is held at 0, tick_o=0, sq_o=0.
//  en_i[ch]=0: cnt is cleared to 0 and tick_o=0. sq_o holds its last value.
//   - Re-enabling restarts from cnt=0.
//  Divisor write (div_wr_i=1 for one cycle; index is div_ch_i):
//   - The value goes to shadow_div[ch] and pend[ch] is set.
//   - Normally it is copied to active_div on the next wrap, so the current period always completes.
//   - It is applied immediately (and pend cleared) if the channel is disabled or active_div==0.
//   - Writing again before the wrap overwrites the shadow; the last write wins.
//   - div_ch_i>=N_CH: the write is ignored.
//  sync_i=1: every enabled channel's cnt is cleared to 0 on the next edge.
//   - Pending divisors are applied at the same time.
//   - No tick is produced in that cycle, even if a wrap coincided (sync wins).
//   - sq_o is cleared to 0 for all channels, so the channels restart phase-aligned.
//  Priority per channel, highest first: rst_i, en_i=0, sync_i, wrap, count.
//  Reset asserted mid-period: all state returns immediately (asynchronously) to reset values.
//   - Divisors revert to DEF_DIV.
//  Arithmetic:
//   - cnt is CNT_W wide and its compare uses active_div-1.
//   - Handle active_div==0 explicitly so the compare never underflows.
// STRUCTURE
//  Package multi_tick_gen_pkg:
//   - constants CH_IDX_W=4 and MAX_CH=16;
//   - localparam F_CLK_HZ=50_000_000;
//   - function hz_to_div(hz)=F_CLK_HZ/hz, used by instantiating code.
//  Sub-module tick_ch:
//   - one channel: counter, shadow/active divisor, pend flag, tick/sq registers;
//   - inputs: en, sync, wr (already channel-decoded), val.
//  Top level:
//   - decodes div_ch_i into a one-hot write vector;
//   - instantiates tick_ch N_CH times in a generate loop and concatenates the outputs.
// TESTING
//  (bench: DEF_DIV=10, N_CH=4, CNT_W=8)
//  1. Release reset, en=4'hF -> first tick_o on all channels 10 cycles later, then every 10 cycles; sq_o period 20.
//  2. Write div=3 to ch1 mid-period -> ch1 finishes its current 10-cycle period, then ticks every 3 cycles.
//     Other channels are unchanged.
//  3. Write div=0 to ch2 -> after the wrap, ch2 tick_o and sq_o stay 0.
//     Then write div=1 -> ch2 tick_o is high every cycle (the channel is stopped, so the write applies immediately).
//  4. Set ch0 div=4 and ch3 div=6 out of phase, pulse sync_i on a ch0 wrap cycle -> no ch0 tick that cycle.
//     Both channels restart from cnt=0, so their ticks coincide every 12 cycles.
//  5. Drop en_i[1] for 5 cycles, then restore -> no ch1 ticks while low; first tick 10 cycles after re-enable.
//  6. Write with div_ch_i=9 -> no channel changes.
//     Assert rst_i mid-period -> tick_o=sq_o=0 at once; divisors back to 10.

Source files
------------

// File: rtl/multi_tick_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_tick_gen_pkg
// Purpose  : Shared constants and helpers for the multi-channel tick
//            generator. Instantiating code uses hz_to_div() to turn a
//            target tick rate into a divisor for the 50 MHz system clock.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multi_tick_gen_pkg;

    // Width of the channel-select field on the divisor write port
    localparam int CH_IDX_W = 4;

    // Largest channel count the channel-select field can address
    localparam int MAX_CH = 16;

    // System clock frequency the divisors are referenced to
    localparam int unsigned F_CLK_HZ = 50_000_000;

    // Divisor producing a tick rate of hz; a zero rate maps to the
    // stopped divisor (0) rather than dividing by zero.
    function automatic int unsigned hz_to_div(input int unsigned hz);
        if (hz == 0) begin
            return 0;
        end
        return F_CLK_HZ / hz;
    endfunction

endpackage : multi_tick_gen_pkg
`default_nettype wire

// File: rtl/multi_tick_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_tick_gen_if
// Purpose  : Control/status bundle of the multi-channel tick generator.
//            Signal names are given from the generator's point of view.
// Signals  : en_i      [N_CH]      per-channel run enable
//            sync_i                global phase re-sync strobe
//            div_wr_i              divisor write strobe
//            div_ch_i  [CH_IDX_W]  channel index for the write
//            div_val_i [CNT_W]     divisor value to write
//            tick_o    [N_CH]      1-cycle tick per channel
//            sq_o      [N_CH]      50% duty square wave per channel
// Modports : master - drives controls, observes outputs
//            slave  - the tick generator itself
// Revision : 1.0 - initial release
// ============================================================================
interface multi_tick_gen_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24
);
    import multi_tick_gen_pkg::*;

    logic [N_CH-1:0]     en_i;
    logic                sync_i;
    logic                div_wr_i;
    logic [CH_IDX_W-1:0] div_ch_i;
    logic [CNT_W-1:0]    div_val_i;
    logic [N_CH-1:0]     tick_o;
    logic [N_CH-1:0]     sq_o;

    modport master (
        output en_i,
        output sync_i,
        output div_wr_i,
        output div_ch_i,
        output div_val_i,
        input  tick_o,
        input  sq_o
    );

    modport slave (
        input  en_i,
        input  sync_i,
        input  div_wr_i,
        input  div_ch_i,
        input  div_val_i,
        output tick_o,
        output sq_o
    );

endinterface : multi_tick_gen_if
`default_nettype wire

// File: rtl/multi_tick_gen_tick_ch.sv
`default_nettype none
// ============================================================================
// Module   : tick_ch
// Purpose  : One tick-generator channel. A counter runs 0..active_div-1;
//            the cycle after the last count a 1-cycle tick is issued and the
//            square output toggles. New divisors are staged in a shadow
//            register and take effect on the next wrap so a running period
//            is never cut short.
// Ports    : clk_i   system clock
//            rst_i   asynchronous active-high reset
//            en_i    channel run enable
//            sync_i  restart counter in phase, clear square output
//            wr_i    divisor write, already decoded for this channel
//            val_i   divisor value accompanying wr_i
//            tick_o  registered 1-cycle tick
//            sq_o    registered square wave, f_clk/(2*div)
// Revision : 1.0 - initial release
// ============================================================================
module tick_ch #(
    parameter int CNT_W   = 24,
    parameter int DEF_DIV = 12_500_000
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             en_i,
    input  wire logic             sync_i,
    input  wire logic             wr_i,
    input  wire logic [CNT_W-1:0] val_i,
    output logic                  tick_o,
    output logic                  sq_o
);

    localparam logic [CNT_W-1:0] C_DEF_DIV = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] act_q,  act_d;
    logic [CNT_W-1:0] shd_q,  shd_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q,   sq_d;

    logic             w_pend;
    logic             w_stopped;
    logic             w_wrap;

    // A write in this very cycle counts as pending, so a write that lands
    // on a wrap/sync/disable cycle is applied straight away.
    assign w_pend    = pend_q | wr_i;

    // active_div==0 is tested first so the active_div-1 compare is only
    // evaluated for a non-zero divisor and can never underflow.
    assign w_stopped = (act_q == '0);
    assign w_wrap    = !w_stopped && (cnt_q == (act_q - C_ONE));

    always_comb begin
        shd_d  = wr_i ? val_i : shd_q;
        cnt_d  = cnt_q;
        act_d  = act_q;
        pend_d = w_pend;
        tick_d = 1'b0;
        sq_d   = sq_q;

        if (!en_i) begin
            // Disabled: no period in flight, so a new divisor applies now.
            cnt_d = '0;
            if (w_pend) begin
                act_d  = shd_d;
                pend_d = 1'b0;
            end
        end else if (w_stopped) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            if (w_pend) begin
                act_d  = shd_d;
                pend_d = 1'b0;
            end
        end else if (sync_i) begin
            // Sync outranks a coincident wrap: no tick this cycle.
            cnt_d = '0;
            sq_d  = 1'b0;
            if (w_pend) begin
                act_d  = shd_d;
                pend_d = 1'b0;
            end
        end else if (w_wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            if (w_pend) begin
                act_d  = shd_d;
                pend_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + C_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            act_q  <= C_DEF_DIV;
            shd_q  <= C_DEF_DIV;
            pend_q <= 1'b0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule : tick_ch
`default_nettype wire

// File: rtl/multi_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : multi_tick_gen
// Purpose  : Multi-channel programmable tick generator. Derives N_CH
//            independent tick/square strobes from the system clock, each
//            with its own run-time divisor, plus a global phase re-sync.
// Ports    : clk_i  system clock (50 MHz)
//            rst_i  asynchronous active-high reset
//            bus    multi_tick_gen_if.slave: en_i, sync_i, div_wr_i,
//                   div_ch_i, div_val_i in; tick_o, sq_o out
// Params   : N_CH    number of channels (1..16)
//            CNT_W   divisor/counter width
//            DEF_DIV divisor loaded into every channel at reset
// Revision : 1.0 - initial release
// ============================================================================
module multi_tick_gen
    import multi_tick_gen_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 24,
    parameter int DEF_DIV = 12_500_000
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    multi_tick_gen_if.slave  bus
);

    logic [N_CH-1:0] w_wr;
    logic [N_CH-1:0] w_tick;
    logic [N_CH-1:0] w_sq;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            // Full-width index compare: indices >= N_CH match no channel,
            // so such writes are dropped rather than aliased.
            assign w_wr[i] = bus.div_wr_i && (bus.div_ch_i == CH_IDX_W'(i));

            tick_ch #(
                .CNT_W   (CNT_W),
                .DEF_DIV (DEF_DIV)
            ) u_tick_ch (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .en_i    (bus.en_i[i]),
                .sync_i  (bus.sync_i),
                .wr_i    (w_wr[i]),
                .val_i   (bus.div_val_i),
                .tick_o  (w_tick[i]),
                .sq_o    (w_sq[i])
            );
        end
    endgenerate

    assign bus.tick_o = w_tick;
    assign bus.sq_o   = w_sq;

endmodule : multi_tick_gen
`default_nettype wire

// File: tb/tb_multi_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_tick_gen
// Purpose  : Directed self-checking bench for multi_tick_gen
//            (N_CH=4, CNT_W=8, DEF_DIV=10). Expected values are
//            hand-computed step indices; step t is sampled 1 ns after the
//            t-th rising edge following enable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_tick_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   t   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic acc;

    always #5 clk = ~clk;

    multi_tick_gen_if #(.N_CH(4), .CNT_W(8)) bus ();

    multi_tick_gen #(
        .N_CH    (4),
        .CNT_W   (8),
        .DEF_DIV (10)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s (t=%0d): got %0h expected %0h", tag, t, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int n);
        while (t < n) step();
    endtask

    // Write takes effect on the next edge; leaves t advanced by one.
    task automatic wr_div(input logic [3:0] ch, input logic [7:0] val);
        bus.div_wr_i  = 1'b1;
        bus.div_ch_i  = ch;
        bus.div_val_i = val;
        step();
        bus.div_wr_i  = 1'b0;
    endtask

    initial begin
        bus.en_i      = 4'h0;
        bus.sync_i    = 1'b0;
        bus.div_wr_i  = 1'b0;
        bus.div_ch_i  = 4'h0;
        bus.div_val_i = 8'h00;

        // Reset state
        step();
        step();
        chk("rst_tick", 32'(bus.tick_o), 32'h0);
        chk("rst_sq",   32'(bus.sq_o),   32'h0);

        // 1. Default divisor 10 on all channels
        rst = 1'b0;
        bus.en_i = 4'hF;
        t = 0;
        run_to(9);   chk("t1_no_tick_9",  32'(bus.tick_o), 32'h0);
        run_to(10);  chk("t1_tick_10",    32'(bus.tick_o), 32'hF);
                     chk("t1_sq_10",      32'(bus.sq_o),   32'hF);
        run_to(11);  chk("t1_no_tick_11", 32'(bus.tick_o), 32'h0);
        run_to(19);  chk("t1_sq_19",      32'(bus.sq_o),   32'hF);
        run_to(20);  chk("t1_tick_20",    32'(bus.tick_o), 32'hF);
                     chk("t1_sq_20",      32'(bus.sq_o),   32'h0);

        // 2. ch1 <- 3 mid-period: applies at the wrap on step 30
        run_to(25);
        wr_div(4'd1, 8'd3);
        run_to(30);  chk("t2_tick_30", 32'(bus.tick_o), 32'hF);
        run_to(33);  chk("t2_tick_33", 32'(bus.tick_o), 32'h2);
        run_to(36);  chk("t2_tick_36", 32'(bus.tick_o), 32'h2);
        run_to(40);  chk("t2_tick_40", 32'(bus.tick_o), 32'hD);

        // 3. ch2 <- 0 (stops after wrap at 50), then ch2 <- 1
        wr_div(4'd2, 8'd0);
        run_to(50);  chk("t3_ch2_last_tick", 32'(bus.tick_o[2]), 32'h1);
        acc = 1'b0;
        while (t < 55) begin
            step();
            acc = acc | bus.tick_o[2] | bus.sq_o[2];
        end
        chk("t3_ch2_stopped", 32'(acc), 32'h0);
        wr_div(4'd2, 8'd1);
        run_to(57);  chk("t3_ch2_tick_57", 32'(bus.tick_o[2]), 32'h1);
                     chk("t3_ch2_sq_57",   32'(bus.sq_o[2]),   32'h1);
        run_to(58);  chk("t3_ch2_tick_58", 32'(bus.tick_o[2]), 32'h1);
                     chk("t3_ch2_sq_58",   32'(bus.sq_o[2]),   32'h0);

        // 4. ch0 <- 4 (active from 70), ch3 <- 6 (active from 80), sync at 82
        run_to(60);
        wr_div(4'd0, 8'd4);
        run_to(70);
        wr_div(4'd3, 8'd6);
        run_to(81);
        bus.sync_i = 1'b1;
        step();
        bus.sync_i = 1'b0;
        chk("t4_sync_tick", 32'(bus.tick_o), 32'h0);
        chk("t4_sync_sq",   32'(bus.sq_o),   32'h0);
        run_to(86);  chk("t4_tick_86", 32'(bus.tick_o), 32'h5);
        run_to(88);  chk("t4_tick_88", 32'(bus.tick_o), 32'hE);
        run_to(94);  chk("t4_tick_94", 32'(bus.tick_o), 32'hF);
                     chk("t4_sq_94",   32'(bus.sq_o),   32'h1);

        // 5. Drop en[1] for 5 cycles; divisor 10 written while disabled
        bus.en_i = 4'b1101;
        wr_div(4'd1, 8'd10);
        acc = bus.tick_o[1];
        while (t < 99) begin
            step();
            acc = acc | bus.tick_o[1];
        end
        bus.en_i = 4'hF;
        while (t < 108) begin
            step();
            acc = acc | bus.tick_o[1];
        end
        chk("t5_ch1_quiet", 32'(acc), 32'h0);
        run_to(109); chk("t5_ch1_tick_109", 32'(bus.tick_o[1]), 32'h1);

        // 6. Out-of-range write is ignored; async reset mid-period
        run_to(110);
        wr_div(4'd9, 8'd5);
        run_to(124); chk("t6_ch1_no_tick_124", 32'(bus.tick_o[1]), 32'h0);
        run_to(126); chk("t6_ch0_tick_126",    32'(bus.tick_o[0]), 32'h1);
        run_to(129); chk("t6_ch1_tick_129",    32'(bus.tick_o[1]), 32'h1);
        run_to(130); chk("t6_tick_130",        32'(bus.tick_o),    32'hD);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_tick", 32'(bus.tick_o), 32'h0);
        chk("t6_rst_sq",   32'(bus.sq_o),   32'h0);
        step();
        rst = 1'b0;
        t = 0;
        run_to(4);   chk("t6_post_rst_4",  32'(bus.tick_o), 32'h0);
        run_to(9);   chk("t6_post_rst_9",  32'(bus.tick_o), 32'h0);
        run_to(10);  chk("t6_post_rst_10", 32'(bus.tick_o), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_multi_tick_gen
`default_nettype wire
